// File: rtl/spi_slave_if_pkg.sv
// spi_slave_if_pkg: shared state encoding, widths and command codes for the SPI slave
package spi_slave_if_pkg;
  localparam int FRAME_W = 10;
  localparam int PAYLOAD_W = 8;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: serial-in/parallel-out receive path and parallel-load/serial-out transmit path
module spi_shift_reg import spi_slave_if_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en_i,
  input  logic                 rx_bit_i,
  input  logic                 rx_last_i,
  input  logic                 tx_load_i,
  input  logic                 tx_en_i,
  input  logic [PAYLOAD_W-1:0] tx_din_i,
  output logic [FRAME_W-1:0]   rx_data_o,
  output logic                 tx_msb_o
);
  logic [FRAME_W-2:0]   rx_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic [PAYLOAD_W-1:0] tx_q;
  // Receive: the final bit goes straight into the held parallel word, so only 9 bits need storing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q      <= '0;
      rx_data_q <= '0;
    end else begin
      if (rx_en_i) rx_q <= {rx_q[FRAME_W-3:0], rx_bit_i};
      if (rx_last_i) rx_data_q <= {rx_q, rx_bit_i};
    end
  end
  // Transmit: load the read byte, then shift left so the MSB leads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= '0;
    else if (tx_load_i) tx_q <= tx_din_i;
    else if (tx_en_i) tx_q <= {tx_q[PAYLOAD_W-2:0], 1'b0};
  end
  assign rx_data_o = rx_data_q;
  assign tx_msb_o  = tx_q[PAYLOAD_W-1];
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave frame decoder for a RAM; optional frame_err output with SPI_FRAME_ERR_EN
module spi_slave_if import spi_slave_if_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [FRAME_W-1:0]   rx_data,
  output logic                 rx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);
  state_e     state_q;
  logic [3:0] cnt_q;
  logic       done_q;
  logic       busy_q;
  logic       sent_q;
  logic       rd_addr_flag_q;
  logic       rx_valid_q;
  logic       rx_en;
  logic       rx_last;
  logic       tx_load;
  logic       tx_en;
  logic       tx_msb;
  // Shift-register controls; a high SS_n suppresses every action
  always_comb begin
    rx_en   = !SS_n && (state_q == CHK_CMD ||
              (state_q inside {WRITE, READ_ADD, READ_DATA} && !done_q));
    rx_last = rx_en && state_q != CHK_CMD && cnt_q == 4'd8;
    tx_load = !SS_n && state_q == READ_DATA && done_q && !busy_q && !sent_q && tx_valid;
    tx_en   = !SS_n && busy_q && cnt_q != 4'd7;
  end
  // Frame FSM: bit counting, rx strobe, read-address flag and MISO shift phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      sent_q         <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      rx_valid_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        sent_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE:    state_q <= CHK_CMD;
          CHK_CMD: begin
            state_q <= !MOSI ? WRITE : rd_addr_flag_q ? READ_DATA : READ_ADD;
            cnt_q   <= '0;
          end
          default: begin
            if (rx_last) begin
              rx_valid_q <= 1'b1;
              done_q     <= 1'b1;
              cnt_q      <= '0;
              if (state_q == READ_ADD) rd_addr_flag_q <= 1'b1;
              if (state_q == READ_DATA) rd_addr_flag_q <= 1'b0;
            end else if (!done_q) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (tx_load) begin
              busy_q <= 1'b1;
              cnt_q  <= '0;
            end else if (busy_q) begin
              if (cnt_q == 4'd7) begin
                busy_q <= 1'b0;
                sent_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end
`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q;
  // Flag a frame cut short before its last rx bit or before the read byte finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else frame_err_q <= SS_n && state_q != IDLE &&
                        (!done_q || (state_q == READ_DATA && !sent_q));
  end
  assign frame_err = frame_err_q;
`endif
  spi_shift_reg u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en_i   (rx_en),
    .rx_bit_i  (MOSI),
    .rx_last_i (rx_last),
    .tx_load_i (tx_load),
    .tx_en_i   (tx_en),
    .tx_din_i  (tx_data),
    .rx_data_o (rx_data),
    .tx_msb_o  (tx_msb)
  );
  assign rx_valid = rx_valid_q;
  assign MISO     = busy_q & tx_msb;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed self-checking bench for spi_slave_if
module tb_spi_slave_if;
  import spi_slave_if_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  int         total = 0;
  int         bad = 0;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif
  spi_slave_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [9:0] f);
    SS_n = 1'b0;
    tick;
    for (int i = 9; i >= 0; i--) begin
      chk("no_early_valid", 16'(rx_valid), 16'h0);
      MOSI = f[i];
      tick;
    end
    MOSI = 1'b0;
    chk("rx_valid", 16'(rx_valid), 16'h1);
    chk("rx_data", 16'(rx_data), 16'(f));
  endtask
  task automatic close;
    SS_n = 1'b1;
    tick;
  endtask
  initial begin
    logic [7:0] b;
    tick;
    tick;
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_rx_data", 16'(rx_data), 16'h000);
    chk("rst_state", 16'(dut.state_q), 16'(IDLE));
    rst_n = 1'b1;
    tick;
    // write frames; tx_valid held high must not start a MISO shift
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    send(10'h005);
    tick;
    chk("valid_one_cycle", 16'(rx_valid), 16'h0);
    chk("rx_data_hold", 16'(rx_data), 16'h005);
    MOSI = 1'b1;
    tick;
    tick;
    chk("extra_bits_no_valid", 16'(rx_valid), 16'h0);
    chk("miso_idle_write", 16'(MISO), 16'h0);
    MOSI = 1'b0;
    tx_valid = 1'b0;
    close;
    send(10'h1AA);
    close;
    chk("flag_after_write", 16'(dut.rd_addr_flag_q), 16'h0);
    // read address then read data
    send(10'h205);
    chk("flag_set", 16'(dut.rd_addr_flag_q), 16'h1);
    close;
    SS_n = 1'b0;
    tick;
    MOSI = 1'b1;
    tick;
    chk("route_read_data", 16'(dut.state_q), 16'(READ_DATA));
    close;
    send(10'h3C3);
    chk("flag_cleared", 16'(dut.rd_addr_flag_q), 16'h0);
    chk("miso_wait", 16'(MISO), 16'h0);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    b = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      chk("miso_bit", 16'(MISO), 16'(b[i]));
      tick;
    end
    chk("miso_after", 16'(MISO), 16'h0);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick;
    tick;
    chk("miso_no_reload", 16'(MISO), 16'h0);
    tx_valid = 1'b0;
    close;
    // aborted frame after 5 bits
    SS_n = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      MOSI = i[0];
      tick;
      chk("abort_no_valid", 16'(rx_valid), 16'h0);
    end
    close;
    chk("abort_idle", 16'(dut.state_q), 16'(IDLE));
    chk("abort_no_valid2", 16'(rx_valid), 16'h0);
    chk("abort_hold", 16'(rx_data), 16'h3C3);
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_pulse", 16'(frame_err), 16'h1);
    tick;
    chk("frame_err_clear", 16'(frame_err), 16'h0);
`endif
    send(10'h0F0);
    close;
    // tx_valid in the same cycle as SS_n rising is ignored
    send(10'h2AA);
    close;
    send(10'h3AA);
    SS_n = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick;
    tx_valid = 1'b0;
    chk("ssn_rise_txv_miso", 16'(MISO), 16'h0);
    chk("ssn_rise_flag", 16'(dut.rd_addr_flag_q), 16'h0);
    tick;
    chk("ssn_rise_txv_miso2", 16'(MISO), 16'h0);
    // reset during the MISO shift
    send(10'h205);
    close;
    send(10'h300);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    tick;
    tick;
    chk("pre_reset_miso", 16'(MISO), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_miso", 16'(MISO), 16'h0);
    chk("async_rx_valid", 16'(rx_valid), 16'h0);
    chk("async_rx_data", 16'(rx_data), 16'h000);
    chk("async_flag", 16'(dut.rd_addr_flag_q), 16'h0);
    SS_n = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    send(10'h1AA);
    close;
    send(10'h2F0);
    chk("post_reset_read_addr", 16'(dut.rd_addr_flag_q), 16'h1);
    close;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 Port rst_n, input, 1, asynchronous active-low reset.
REQ-003 Port SS_n, input, 1, SPI slave select, active low; frame = contiguous low period.
REQ-004 Port MOSI, input, 1, serial data from master, sampled on clk rising edge, MSB first.
REQ-005 Port MISO, output, 1, serial read data to master, MSB first.
REQ-006 Port rx_data, output, 10, parallel frame to RAM: [9:8] command, [7:0] address/data.
REQ-007 Port rx_valid, output, 1, one-cycle strobe qualifying rx_data.
REQ-008 Port tx_data, input, 8, read data returned by RAM.
REQ-009 Port tx_valid, input, 1, qualifies tx_data.
REQ-010 Parameter none; frame width fixed at 10 bits, read payload fixed at 8 bits.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD when SS_n sampled 0; no bit captured in IDLE.
REQ-013 CHK_CMD samples MOSI as bit 9: 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 In WRITE/READ_ADD/READ_DATA, shift remaining bits 8..0 on 9 consecutive cycles into a 10-bit shift register (bit 9 from CHK_CMD).
REQ-015 Cycle after bit 0 captured: rx_data = full 10-bit frame, rx_valid = 1 for exactly one cycle; bits forwarded unmodified even if [9:8] disagrees with state.
REQ-016 Extra MOSI bits after bit 0 in WRITE/READ_ADD ignored until SS_n rises.
REQ-017 rd_addr_flag set on a completed READ_ADD frame, cleared on a completed READ_DATA frame, unchanged by WRITE frames.
REQ-018 READ_DATA after rx_valid: wait for tx_valid=1, capture tx_data, then drive MISO = tx_data[7] .. tx_data[0] on next 8 cycles, one bit per cycle.
REQ-019 MISO SHALL be 0 whenever not shifting read data.
REQ-020 SS_n sampled 1 in any state: next state IDLE; partial frame discarded, no rx_valid, rd_addr_flag unchanged; in-progress MISO shift aborted.
REQ-021 tx_valid outside READ_DATA wait phase ignored; tx_valid in same cycle as SS_n rise ignored.
REQ-022 rx_data holds last value between strobes.

Reset
REQ-023 rst_n low: state IDLE, rx_valid 0, rx_data 10'h000, MISO 0, rd_addr_flag 0, counters 0, immediately and independent of clk.
REQ-024 Reset mid-frame SHALL drop the frame; first frame after release begins at next SS_n low.

Configuration
REQ-025 Macro SPI_FRAME_ERR_EN defined: extra output frame_err (1 bit) pulses high one cycle when SS_n rises before a frame's bit 0 or before 8 MISO bits complete; reset 0.
REQ-026 SPI_FRAME_ERR_EN undefined: no frame_err port, no related logic; all other behaviour identical.

Structure
REQ-027 Shared package holds state encoding, frame width (10), payload width (8), command codes 2'b00 wr-addr, 2'b01 wr-data, 2'b10 rd-addr, 2'b11 rd-data.
REQ-028 One sub-module spi_shift_reg (serial-in/parallel-out receive, parallel-load/serial-out transmit); FSM stays in spi_slave_if.

Verification
REQ-029 Frame 10'b00_0000_0101 then 10'b01_1010_1010 -> rx_valid pulses carrying 0x005 then 0x1AA, each 1 cycle after bit 0.
REQ-030 Read-address frame 10'b10_0000_0101 -> rx_data 0x205, rd_addr_flag 1; next frame 10'b11_xxxx_xxxx routed to READ_DATA.
REQ-031 READ_DATA with tx_valid=1, tx_data=8'hA5 -> MISO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_flag 0.
REQ-032 SS_n rises after 5 bits -> no rx_valid, state IDLE next cycle; with SPI_FRAME_ERR_EN frame_err pulses once.
REQ-033 rst_n asserted mid-MISO shift -> MISO, rx_valid 0 asynchronously, rd_addr_flag 0, next full frame handled normally.
